// File: rtl/cnt_seq_pkg.sv
// Shared constants for the counter-sequence checker: FSM state encodings,
// state width, the good-run counter width and the default lock threshold.
package cnt_seq_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_SYNC = 2'd1;
  localparam logic [STATE_W-1:0] ST_LOCK = 2'd2;
  localparam logic [STATE_W-1:0] ST_ERR  = 2'd3;

  // good_run must be able to hold the largest legal LOCK_N (15)
  localparam int GOOD_RUN_W = 4;

  localparam int LOCK_N_DEF = 2;

endpackage

// File: rtl/cnt_seq_sat_inc.sv
// Saturating incrementer: nxt_o = val_i + 1 when en_i and val_i < MAX,
// otherwise val_i unchanged. Purely combinational.
module cnt_seq_sat_inc #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic [W-1:0] nxt_o
);

  // Increment unless disabled or already at the ceiling
  always_comb begin
    nxt_o = val_i;
    if (en_i && (val_i != MAX)) begin
      nxt_o = val_i + {{(W-1){1'b0}}, 1'b1};
    end else begin
      nxt_o = val_i;
    end
  end

endmodule

// File: rtl/cnt_seq_checker.sv
// Counter-sequence checker: watches an up-counter and verifies strict +1
// (mod 2^CNT_W) progression on valid samples. Reports lock, wrap pulse and
// wrap count, plus sticky/saturating error status. All outputs registered.
// Optional build macro CNT_SEQ_CHECKER_STALL_EN: when defined, a repeated
// value (cnt_in == prev) is a legal stall rather than a mismatch.
module cnt_seq_checker
  import cnt_seq_pkg::*;
#(
  parameter int CNT_W  = 3,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_vld,
  input  logic              clr_err,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [GOOD_RUN_W-1:0] LOCK_N_V = GOOD_RUN_W'(LOCK_N);
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};

  logic [STATE_W-1:0]    state_q, state_d;
  logic [CNT_W-1:0]      prev_q, prev_d;
  logic [GOOD_RUN_W-1:0] good_run_q, good_run_d, good_run_inc_s;
  logic                  locked_q, locked_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0]     wrap_cnt_q, wrap_cnt_d;
  logic                  err_flag_q, err_flag_d;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;

  logic [CNT_W-1:0]      prev_inc_s;
  logic                  match_s;
  logic                  stall_s;
  logic                  gr_inc_en_s;
  logic                  err_evt_s;

  // Expected next value (wraps naturally at CNT_W bits) and sample classification
  always_comb begin
    prev_inc_s = prev_q + {{(CNT_W-1){1'b0}}, 1'b1};
    match_s    = (cnt_in == prev_inc_s);
`ifdef CNT_SEQ_CHECKER_STALL_EN
    stall_s    = (cnt_in == prev_q);
`else
    stall_s    = 1'b0;
`endif
  end

  // Increment enables for the good-run and error counters
  always_comb begin
    gr_inc_en_s = cnt_vld && (state_q == ST_SYNC) && !stall_s && match_s;
    err_evt_s   = cnt_vld && (state_q == ST_LOCK) && !stall_s && !match_s;
  end

  cnt_seq_sat_inc #(
    .W   (GOOD_RUN_W),
    .MAX (LOCK_N_V)
  ) u_good_run_inc (
    .val_i (good_run_q),
    .en_i  (gr_inc_en_s),
    .nxt_o (good_run_inc_s)
  );

  cnt_seq_sat_inc #(
    .W   (ERR_W),
    .MAX ({ERR_W{1'b1}})
  ) u_err_cnt_inc (
    .val_i (err_cnt_q),
    .en_i  (err_evt_s),
    .nxt_o (err_cnt_d)
  );

  // Sequence-tracking FSM and status next-state logic
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_run_d   = good_run_q;
    locked_d     = locked_q;
    wrap_pulse_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;

    // A new error on the same edge overrides the clear below
    if (clr_err) begin
      err_flag_d = 1'b0;
    end else begin
      err_flag_d = err_flag_q;
    end

    if (cnt_vld) begin
      prev_d = cnt_in;
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_SYNC;
          good_run_d = {GOOD_RUN_W{1'b0}};
        end
        ST_SYNC: begin
          if (stall_s) begin
            good_run_d = good_run_q;
          end else if (match_s) begin
            good_run_d = good_run_inc_s;
            if (good_run_inc_s == LOCK_N_V) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
            end else begin
              state_d  = ST_SYNC;
            end
          end else begin
            good_run_d = {GOOD_RUN_W{1'b0}};
          end
        end
        ST_LOCK: begin
          if (stall_s) begin
            state_d = ST_LOCK;
          end else if (match_s) begin
            if (prev_q == CNT_MAX) begin
              wrap_pulse_d = 1'b1;
              wrap_cnt_d   = wrap_cnt_q + {{(WRAP_W-1){1'b0}}, 1'b1};
            end else begin
              wrap_pulse_d = 1'b0;
            end
          end else begin
            state_d    = ST_ERR;
            locked_d   = 1'b0;
            err_flag_d = 1'b1;
          end
        end
        ST_ERR: begin
          state_d    = ST_SYNC;
          good_run_d = {GOOD_RUN_W{1'b0}};
        end
        default: begin
          state_d    = ST_IDLE;
          good_run_d = {GOOD_RUN_W{1'b0}};
          locked_d   = 1'b0;
        end
      endcase
    end else begin
      prev_d = prev_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      prev_q       <= {CNT_W{1'b0}};
      good_run_q   <= {GOOD_RUN_W{1'b0}};
      locked_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= {WRAP_W{1'b0}};
      err_flag_q   <= 1'b0;
      err_cnt_q    <= {ERR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_run_q   <= good_run_d;
      locked_q     <= locked_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      err_flag_q   <= err_flag_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign err_flag   = err_flag_q;
  assign err_cnt    = err_cnt_q;

endmodule
